// File: rtl/umi_messages_pkg.sv
// Shared UMI message definitions: opcodes, command field positions, request
// command packing and the register-host FSM state type.
package umi_messages_pkg;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned SIZE_LSB   = 5;
  localparam int unsigned LEN_LSB    = 8;
  localparam int unsigned PROT_LSB   = 20;
  localparam int unsigned EOM_BIT    = 22;
  localparam int unsigned ERR_LSB    = 25;

  typedef enum logic [1:0] {StIdle, StReq, StWait} host_state_e;

  function automatic logic [31:0] pack_req_cmd(input logic [4:0] opcode,
                                               input logic [2:0] size,
                                               input logic [7:0] len,
                                               input logic [1:0] prot);
    logic [31:0] cmd;
    cmd = '0;
    cmd[OPCODE_LSB +: 5] = opcode;
    cmd[SIZE_LSB +: 3]   = size;
    cmd[LEN_LSB +: 8]    = len;
    cmd[PROT_LSB +: 2]   = prot;
    cmd[EOM_BIT]         = 1'b1;
    return cmd;
  endfunction

endpackage

// File: rtl/umi_reg_host_cmdpack.sv
// Combinational UMI command builder for single-beat register requests, plus
// the check that a response opcode matches the request type.
module umi_reg_host_cmdpack
  import umi_messages_pkg::*;
#(
  parameter int unsigned CW = 32,
  parameter int unsigned RW = 32
) (
  input  logic          write,
  input  logic [1:0]    prot,
  input  logic [4:0]    resp_opcode,
  output logic [CW-1:0] req_cmd,
  output logic          resp_opcode_ok
);

  localparam logic [2:0] Size = 3'($clog2(RW / 8));

  assign req_cmd = CW'(pack_req_cmd(write ? REQ_WRITE : REQ_READ, Size, 8'd0, prot));
  assign resp_opcode_ok = (resp_opcode == (write ? RESP_WRITE : RESP_READ));

endmodule

// File: rtl/umi_reg_host.sv
// Register-to-UMI initiator: one outstanding single-beat read/write at a time.
// Optional response timeout enabled by defining UMI_REG_HOST_TIMEOUT_EN.
module umi_reg_host
  import umi_messages_pkg::*;
#(
  parameter int unsigned    CW      = 32,
  parameter int unsigned    AW      = 64,
  parameter int unsigned    DW      = 256,
  parameter int unsigned    RW      = 32,
  parameter logic [AW-1:0]  SRCADDR = '0,
  parameter int unsigned    TOW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reg_valid,
  output logic          reg_ready,
  input  logic          reg_write,
  input  logic [AW-1:0] reg_addr,
  input  logic [RW-1:0] reg_wrdata,
  input  logic [1:0]    reg_prot,
  output logic          reg_done,
  output logic [RW-1:0] reg_rddata,
  output logic [1:0]    reg_err,
  output logic          uhost_req_valid,
  input  logic          uhost_req_ready,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_resp_valid,
  output logic          uhost_resp_ready,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data
);

  host_state_e   state_q;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [RW-1:0] wrdata_q;
  logic [1:0]    prot_q;

  logic [CW-1:0] req_cmd;
  logic          resp_opcode_ok;
  logic          resp_ok;
  logic          unused_resp;

`ifdef UMI_REG_HOST_TIMEOUT_EN
  localparam logic [TOW-1:0] TmoLast = {TOW{1'b1}} - TOW'(1);
  logic [TOW-1:0] tmo_q;
`endif

  umi_reg_host_cmdpack #(
    .CW(CW),
    .RW(RW)
  ) u_cmdpack (
    .write          (write_q),
    .prot           (prot_q),
    .resp_opcode    (uhost_resp_cmd[OPCODE_LSB +: 5]),
    .req_cmd        (req_cmd),
    .resp_opcode_ok (resp_opcode_ok)
  );

  assign resp_ok = resp_opcode_ok && (uhost_resp_dstaddr == SRCADDR);

  // Request fields read as zero whenever no request is being offered.
  assign uhost_req_cmd     = uhost_req_valid ? req_cmd : '0;
  assign uhost_req_dstaddr = uhost_req_valid ? addr_q : '0;
  assign uhost_req_srcaddr = uhost_req_valid ? SRCADDR : '0;
  assign uhost_req_data    = uhost_req_valid ? DW'(wrdata_q) : '0;

  assign unused_resp = ^{uhost_resp_cmd, uhost_resp_srcaddr, uhost_resp_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      write_q          <= 1'b0;
      addr_q           <= '0;
      wrdata_q         <= '0;
      prot_q           <= '0;
      reg_ready        <= 1'b0;
      reg_done         <= 1'b0;
      reg_rddata       <= '0;
      reg_err          <= '0;
      uhost_req_valid  <= 1'b0;
      uhost_resp_ready <= 1'b0;
`ifdef UMI_REG_HOST_TIMEOUT_EN
      tmo_q            <= '0;
`endif
    end else begin
      reg_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          reg_ready <= 1'b1;
          if (reg_valid && reg_ready) begin
            write_q         <= reg_write;
            addr_q          <= reg_addr;
            wrdata_q        <= reg_write ? reg_wrdata : '0;
            prot_q          <= reg_prot;
            reg_ready       <= 1'b0;
            uhost_req_valid <= 1'b1;
            state_q         <= StReq;
          end
        end
        StReq: begin
          if (uhost_req_ready) begin
            uhost_req_valid  <= 1'b0;
            uhost_resp_ready <= 1'b1;
            state_q          <= StWait;
`ifdef UMI_REG_HOST_TIMEOUT_EN
            tmo_q            <= '0;
`endif
          end
        end
        StWait: begin
`ifdef UMI_REG_HOST_TIMEOUT_EN
          tmo_q <= tmo_q + TOW'(1);
`endif
          if (uhost_resp_valid) begin
            uhost_resp_ready <= 1'b0;
            reg_done         <= 1'b1;
            reg_err          <= resp_ok ? uhost_resp_cmd[ERR_LSB +: 2] : 2'b11;
            reg_rddata       <= (resp_ok && !write_q) ? uhost_resp_data[RW-1:0] : '0;
            state_q          <= StIdle;
          end
`ifdef UMI_REG_HOST_TIMEOUT_EN
          // Counter reaches all-ones on this edge: give up on the response.
          else if (tmo_q == TmoLast) begin
            uhost_resp_ready <= 1'b0;
            reg_done         <= 1'b1;
            reg_err          <= 2'b10;
            reg_rddata       <= '0;
            state_q          <= StIdle;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_reg_host.sv
// Randomized self-checking bench for umi_reg_host; the bench acts as both the
// register master and the UMI responder.
module tb_umi_reg_host;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int RW = 32;
  localparam logic [63:0] SRC = 64'h0000_0001_CAFE_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_valid, reg_ready, reg_write, reg_done;
  logic [AW-1:0] reg_addr;
  logic [RW-1:0] reg_wrdata, reg_rddata;
  logic [1:0]    reg_prot, reg_err;
  logic          uhost_req_valid, uhost_req_ready;
  logic [CW-1:0] uhost_req_cmd;
  logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
  logic [DW-1:0] uhost_req_data;
  logic          uhost_resp_valid, uhost_resp_ready;
  logic [CW-1:0] uhost_resp_cmd;
  logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
  logic [DW-1:0] uhost_resp_data;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  // Observations captured by do_txn for the calling test to judge.
  logic [CW-1:0] o_cmd;
  logic [AW-1:0] o_dst, o_src;
  logic [DW-1:0] o_data;
  logic [RW-1:0] o_rd;
  logic [1:0]    o_err;
  bit            o_stable, o_done, o_pulse_ok;
  int            o_lat;

  umi_reg_host #(
    .CW(CW), .AW(AW), .DW(DW), .RW(RW), .SRCADDR(SRC), .TOW(4)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wrdata(reg_wrdata), .reg_prot(reg_prot),
    .reg_done(reg_done), .reg_rddata(reg_rddata), .reg_err(reg_err),
    .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
    .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
    .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
    .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
    .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (uhost_req_valid && uhost_req_ready) hs_cnt <= hs_cnt + 1;
    if (reg_done) done_cnt <= done_cnt + 1;
  end

  // UMI command a correct request must carry: opcode, size=log2(4)=2, len 0, prot, eom.
  function automatic logic [31:0] exp_cmd(input bit wr, input logic [1:0] prot);
    return (wr ? 32'd3 : 32'd1) + (32'd2 << 5) + (32'(prot) << 20) + (32'd1 << 22);
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // kind: 0 good response, 1 wrong opcode, 2 wrong dstaddr.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [RW-1:0] wd,
                        input logic [1:0] prot, input int stall, input int dly,
                        input int kind, input logic [RW-1:0] rd, input logic [1:0] rerr);
    int n;
    logic [4:0] op;
    o_done = 0; o_pulse_ok = 0; o_lat = 0;
    reg_valid = 1; reg_write = wr; reg_addr = addr; reg_wrdata = wd; reg_prot = prot;
    n = 0;
    while (!reg_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    reg_valid = 0; reg_wrdata = $urandom; reg_addr = {$urandom, $urandom}; reg_prot = 2'($urandom);
    o_lat = 1;
    n = 0;
    while (!uhost_req_valid && n < 50) begin @(negedge clk); n++; o_lat++; end
    o_cmd = uhost_req_cmd; o_dst = uhost_req_dstaddr; o_src = uhost_req_srcaddr;
    o_data = uhost_req_data;
    o_stable = uhost_req_valid && !reg_ready;
    for (int i = 0; i < stall; i++) begin
      uhost_resp_valid = 1;
      @(negedge clk); o_lat++;
      if (uhost_req_cmd !== o_cmd || uhost_req_dstaddr !== o_dst || uhost_req_srcaddr !== o_src
          || uhost_req_data !== o_data || !uhost_req_valid || reg_ready || uhost_resp_ready)
        o_stable = 0;
    end
    uhost_resp_valid = 0;
    uhost_req_ready = 1;
    @(negedge clk); o_lat++;
    uhost_req_ready = 0;
    for (int i = 0; i < dly; i++) begin @(negedge clk); o_lat++; end
    if (kind == 1) op = wr ? 5'h02 : 5'h04;
    else op = wr ? 5'h04 : 5'h02;
    uhost_resp_cmd = 32'(op) | (32'(rerr) << 25) | (32'($urandom_range(0, 3)) << 27);
    uhost_resp_dstaddr = (kind == 2) ? (SRC ^ 64'h40) : SRC;
    uhost_resp_srcaddr = addr;
    uhost_resp_data = rand_wide();
    uhost_resp_data[RW-1:0] = rd;
    uhost_resp_valid = 1;
    n = 0;
    while (!uhost_resp_ready && n < 50) begin @(negedge clk); n++; o_lat++; end
    @(negedge clk); o_lat++;
    uhost_resp_valid = 0;
    o_done = reg_done; o_rd = reg_rddata; o_err = reg_err;
    @(negedge clk);
    o_pulse_ok = !reg_done;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_ready, reg_done, uhost_req_valid, uhost_resp_ready} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {reg_ready, reg_done, uhost_req_valid, uhost_resp_ready});
    end
    checks++;
    if (uhost_req_cmd !== '0 || uhost_req_dstaddr !== '0 || uhost_req_srcaddr !== '0 ||
        uhost_req_data !== '0 || reg_rddata !== '0 || reg_err !== '0) begin
      failures++;
      $display("FAIL reset_data: cmd=%h src=%h rd=%h err=%b want all 0",
               uhost_req_cmd, uhost_req_srcaddr, reg_rddata, reg_err);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (reg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", reg_ready);
    end
  endtask

  task automatic test_write_read();
    do_txn(1, 64'h10, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'h0, 2'b00);
    checks++;
    if (o_cmd !== exp_cmd(1, 2'b00) || o_dst !== 64'h10 || o_src !== SRC) begin
      failures++;
      $display("FAIL wr_req: cmd=%h dst=%h src=%h want %h %h %h",
               o_cmd, o_dst, o_src, exp_cmd(1, 2'b00), 64'h10, SRC);
    end
    checks++;
    if (o_data !== DW'(32'hDEADBEEF)) begin
      failures++; $display("FAIL wr_data: got %h want deadbeef", o_data);
    end
    checks++;
    if (!o_done || !o_pulse_ok || o_err !== 2'b00 || o_lat != 3) begin
      failures++;
      $display("FAIL wr_done: done=%0d single=%0d err=%b lat=%0d want 1 1 00 3",
               o_done, o_pulse_ok, o_err, o_lat);
    end
    do_txn(0, 64'h10, 32'h1234_5678, 2'b10, 0, 0, 0, 32'hDEADBEEF, 2'b00);
    checks++;
    if (o_cmd !== exp_cmd(0, 2'b10) || o_data !== '0) begin
      failures++;
      $display("FAIL rd_req: cmd=%h data=%h want %h 0", o_cmd, o_data, exp_cmd(0, 2'b10));
    end
    checks++;
    if (!o_done || o_rd !== 32'hDEADBEEF || o_err !== 2'b00) begin
      failures++;
      $display("FAIL rd_done: done=%0d rd=%h err=%b want 1 deadbeef 00", o_done, o_rd, o_err);
    end
  endtask

  task automatic test_stall();
    int hs0;
    logic [RW-1:0] rd;
    hs0 = hs_cnt;
    rd = $urandom;
    do_txn(0, {$urandom, $urandom}, 32'h0, 2'b01, 5, 1, 0, rd, 2'b01);
    checks++;
    if (!o_stable || hs_cnt - hs0 != 1) begin
      failures++;
      $display("FAIL stall: stable=%0d handshakes=%0d want 1 1", o_stable, hs_cnt - hs0);
    end
    checks++;
    if (!o_done || o_rd !== rd || o_err !== 2'b01) begin
      failures++;
      $display("FAIL stall_done: done=%0d rd=%h err=%b want 1 %h 01", o_done, o_rd, o_err, rd);
    end
  endtask

  task automatic test_bad_resp();
    for (int k = 0; k < 3; k++) begin
      do_txn(k == 2, {$urandom, $urandom}, $urandom, 2'b00, 0, 0, (k == 1) ? 2 : 1,
             32'hA5A5_5A5A, 2'b00);
      checks++;
      if (!o_done || o_err !== 2'b11 || o_rd !== '0) begin
        failures++;
        $display("FAIL bad_resp%0d: done=%0d err=%b rd=%h want 1 11 0", k, o_done, o_err, o_rd);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int d0, n;
    reg_valid = 1; reg_write = 1; reg_addr = 64'h20; reg_wrdata = 32'h0BAD_F00D;
    n = 0;
    while (!reg_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    reg_valid = 0;
    n = 0;
    while (!uhost_req_valid && n < 50) begin @(negedge clk); n++; end
    uhost_req_ready = 1;
    @(negedge clk);
    uhost_req_ready = 0;
    checks++;
    if (uhost_resp_ready !== 1'b1) begin
      failures++; $display("FAIL wait_entry: resp_ready=%b want 1", uhost_resp_ready);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    d0 = done_cnt;
    checks++;
    if ({reg_ready, reg_done, uhost_req_valid, uhost_resp_ready} !== 4'b0 ||
        uhost_req_cmd !== '0 || reg_err !== '0 || reg_rddata !== '0) begin
      failures++;
      $display("FAIL reset_wait: ctrl=%b cmd=%h err=%b want 0",
               {reg_ready, reg_done, uhost_req_valid, uhost_resp_ready}, uhost_req_cmd, reg_err);
    end
    uhost_resp_valid = 1;
    repeat (4) @(negedge clk);
    uhost_resp_valid = 0;
    checks++;
    if (done_cnt != d0) begin
      failures++; $display("FAIL reset_nodone: dones=%0d want 0", done_cnt - d0);
    end
    do_txn(1, 64'h24, 32'h600D_CAFE, 2'b11, 0, 0, 0, 32'h0, 2'b00);
    checks++;
    if (!o_done || o_err !== 2'b00 || o_data !== DW'(32'h600D_CAFE) || o_dst !== 64'h24) begin
      failures++;
      $display("FAIL post_reset_wr: done=%0d err=%b data=%h dst=%h", o_done, o_err, o_data, o_dst);
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] mem [16];
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int t = 0; t < 30; t++) begin
      bit wr;
      int idx, stall, dly, kind;
      logic [RW-1:0] wd, exp_rd;
      logic [1:0] prot, rerr, exp_err;
      logic [DW-1:0] exp_data;
      wr = 1'($urandom); idx = $urandom_range(0, 15); wd = $urandom;
      prot = 2'($urandom); rerr = 2'($urandom_range(0, 2));
      stall = $urandom_range(0, 3); dly = $urandom_range(0, 3);
      kind = $urandom_range(0, 4);
      if (kind > 2) kind = 0;
      // Responder backs a small register file addressed by word index.
      do_txn(wr, 64'(idx * 4), wd, prot, stall, dly, kind, mem[idx], rerr);
      exp_err = (kind == 0) ? rerr : 2'b11;
      exp_rd = (kind == 0 && !wr) ? mem[idx] : '0;
      exp_data = wr ? DW'(wd) : '0;
      if (wr && kind == 0) mem[idx] = wd;
      checks++;
      if (o_cmd !== exp_cmd(wr, prot) || o_dst !== 64'(idx * 4) || o_data !== exp_data ||
          !o_stable) begin
        failures++;
        $display("FAIL rand%0d_req: cmd=%h dst=%h data=%h stable=%0d want %h %h %h 1", t,
                 o_cmd, o_dst, o_data[31:0], o_stable, exp_cmd(wr, prot), idx * 4, wd);
      end
      checks++;
      if (!o_done || !o_pulse_ok || o_err !== exp_err || o_rd !== exp_rd ||
          o_lat != 3 + stall + dly) begin
        failures++;
        $display("FAIL rand%0d_resp: done=%0d single=%0d err=%b rd=%h lat=%0d want 1 1 %b %h %0d",
                 t, o_done, o_pulse_ok, o_err, o_rd, o_lat, exp_err, exp_rd, 3 + stall + dly);
      end
    end
  endtask

`ifdef UMI_REG_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int n, waitc, d0;
    bit late_ok;
    reg_valid = 1; reg_write = 0; reg_addr = 64'h30;
    n = 0;
    while (!reg_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    reg_valid = 0;
    n = 0;
    while (!uhost_req_valid && n < 50) begin @(negedge clk); n++; end
    uhost_req_ready = 1;
    @(negedge clk);
    uhost_req_ready = 0;
    waitc = 0; n = 0;
    while (!reg_done && n < 40) begin
      if (uhost_resp_ready) waitc++;
      @(negedge clk); n++;
    end
    checks++;
    if (!reg_done || waitc != 15 || reg_err !== 2'b10 || reg_rddata !== '0) begin
      failures++;
      $display("FAIL timeout: done=%b wait=%0d err=%b rd=%h want 1 15 10 0",
               reg_done, waitc, reg_err, reg_rddata);
    end
    d0 = done_cnt;
    uhost_resp_cmd = 32'h2; uhost_resp_dstaddr = SRC; uhost_resp_valid = 1;
    late_ok = 1;
    repeat (4) begin @(negedge clk); if (uhost_resp_ready) late_ok = 0; end
    uhost_resp_valid = 0;
    checks++;
    if (!late_ok || done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL late_resp: not_taken=%0d dones=%0d want 1 1", late_ok, done_cnt - d0);
    end
  endtask
`endif

  initial begin
    reg_valid = 0; reg_write = 0; reg_addr = '0; reg_wrdata = '0; reg_prot = '0;
    uhost_req_ready = 0; uhost_resp_valid = 0; uhost_resp_cmd = '0;
    uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0; uhost_resp_data = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_stall();
    test_bad_resp();
    test_reset_in_wait();
    test_random();
`ifdef UMI_REG_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/umi_reg_host.md
Name: umi_reg_host

Overview:
- Initiator-side counterpart of umi_regif. Turns single-beat register read/write transactions from a local controller into UMI requests, then collects the matching UMI response.
- Sits between a simple register master (CSR sequencer, debug bridge) and a UMI request/response channel pair.
- One transaction outstanding at a time.

Parameters:
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 256, UMI data width
- RW, 32, register data width; power of two, 8..DW
- SRCADDR, 64'h0, fixed UMI return address placed on srcaddr
- TOW, 16, timeout counter width (used only with the optional feature)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- reg_valid  input  1  register transaction request
- reg_ready  output  1  request accepted this cycle
- reg_write  input  1  1=write, 0=read
- reg_addr  input  AW  register byte address
- reg_wrdata  input  RW  write data
- reg_prot  input  2  protection bits, copied to cmd PROT
- reg_done  output  1  one-cycle completion pulse
- reg_rddata  output  RW  read data; valid when reg_done
- reg_err  output  2  response error code; valid when reg_done
- uhost_req_valid/ready  output/input  1  UMI request handshake
- uhost_req_cmd  output  CW  UMI request command
- uhost_req_dstaddr  output  AW  UMI destination address
- uhost_req_srcaddr  output  AW  UMI source address
- uhost_req_data  output  DW  UMI request data
- uhost_resp_valid/ready  input/output  1  UMI response handshake
- uhost_resp_cmd  input  CW  UMI response command
- uhost_resp_dstaddr  input  AW  UMI response destination address
- uhost_resp_srcaddr  input  AW  UMI response source address
- uhost_resp_data  input  DW  UMI response data

Behaviour:

Reset:
- Synchronous to clk, active-high.
- While reset is asserted: all outputs 0; state=IDLE; captured registers 0.
- Reset mid-transaction abandons it. No reg_done is emitted.

FSM states: IDLE, REQ, WAIT.
- IDLE:
  - reg_ready=1.
  - On reg_valid, capture write/addr/wrdata/prot and go to REQ.
- REQ:
  - uhost_req_valid=1; all request fields held stable until uhost_req_ready.
  - On handshake: a posted-free write or a read goes to WAIT.
- WAIT:
  - uhost_resp_ready=1.
  - A response is accepted on uhost_resp_valid.
  - Accepting a response produces reg_done=1 for exactly one cycle, then returns to IDLE.
  - A new reg_valid is accepted no earlier than the cycle after reg_done (reg_ready=0 in REQ and WAIT).

Command encoding (fields from the shared package):
- OPCODE = REQ_WRITE (5'h03) or REQ_READ (5'h01).
- SIZE = clog2(RW/8); LEN = 0; PROT = reg_prot; EOM = 1; all other fields 0.
- dstaddr = reg_addr; srcaddr = SRCADDR.
- data = reg_wrdata zero-extended to DW (reads drive 0).

Response checking:
- Expected opcode: RESP_READ (5'h02) for reads, RESP_WRITE (5'h04) for writes.
- On expected opcode:
  - reg_err = cmd ERR field [26:25].
  - reg_rddata = resp_data[RW-1:0] (reads) or 0 (writes).
- On unexpected opcode or dstaddr != SRCADDR:
  - The response is still consumed.
  - reg_err = 2'b11, reg_rddata = 0.

Latency:
- Minimum 3 cycles from reg_valid to reg_done: accept, request handshake, response handshake, with reg_done registered on the cycle after the response handshake.

Simultaneous events:
- uhost_resp_valid arriving while in REQ is not accepted (resp_ready=0); it is held off by the responder.

Optional Feature:
- Macro: UMI_REG_HOST_TIMEOUT_EN.
- Defined:
  - A TOW-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the counter reaches all-ones: reg_done pulses with reg_err=2'b10 and reg_rddata=0, and the FSM returns to IDLE.
  - A late response arriving afterwards in IDLE is not accepted (resp_ready=0).
- Undefined: the counter and its logic are absent, and WAIT waits indefinitely.

Decomposition:
- Package umi_messages_pkg:
  - opcode constants REQ_READ, REQ_WRITE, RESP_READ, RESP_WRITE.
  - cmd field bit positions (OPCODE, SIZE, LEN, PROT, EOM, ERR).
  - function to pack a request cmd.
  - state enum for IDLE/REQ/WAIT.
- Natural sub-module: umi_reg_host_cmdpack. Purely combinational: builds uhost_req_cmd and checks the response opcode; reusable by other UMI initiators.

Test Plan:
- Write addr=0x10, data=0xDEADBEEF; responder replies RESP_WRITE with err=0 -> one UMI request with cmd opcode 0x03, size=2, len=0, data[31:0]=0xDEADBEEF; reg_done one pulse, reg_err=0.
- Read addr=0x10 after the write; responder returns data 0xDEADBEEF -> req opcode 0x01; reg_rddata=0xDEADBEEF, reg_err=0.
- uhost_req_ready held low 5 cycles -> request fields stable for 6 cycles, reg_ready=0 throughout, exactly one handshake.
- Response with opcode 0x04 to a read, or dstaddr != SRCADDR -> response consumed, reg_err=2'b11, reg_rddata=0.
- Reset asserted 1 cycle while in WAIT -> all outputs 0 next cycle, no reg_done; a following write completes normally.
- With UMI_REG_HOST_TIMEOUT_EN and TOW=4, no response -> reg_done after 15 WAIT cycles with reg_err=2'b10; a late response is not accepted.
